mem_read_arbiter: RTL and testbench

//   Shares one single-beat memory read port (m_ar*/m_r*) between two cache-side requesters.
//   s0 is the instruction-fetch side; s1 is the data-cache wrapper miss path.

---
 rtl/mem_read_arbiter.sv | 104 ++++++++++
 tb/tb_mem_read_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
// Two-requester single-beat read arbiter: one outstanding transaction, response routed back to its owner.
// Latency: request handshake -> m_arvalid next cycle; response is a zero-cycle passthrough; owner's rready backpressures memory.
module mem_read_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic                  grant_id
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    grant_q, grant_d;
  logic                    last_q, last_d;
  logic                    winner;

  // On a tie, round-robin favours whoever did not win last time.
  always_comb begin
    if (s0_arvalid && s1_arvalid) begin
      winner = (FIXED_PRIO != 0) ? 1'b1 : ~last_q;
    end else begin
      winner = s1_arvalid;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    grant_d    = grant_q;
    last_d     = last_q;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        s0_arready = s0_arvalid & ~winner;
        s1_arready = s1_arvalid & winner;
        if (s0_arready || s1_arready) begin
          state_d = ADDR;
          addr_d  = winner ? s1_araddr : s0_araddr;
          grant_d = winner;
          last_d  = winner;
        end
      end
      ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = DATA;
      end
      DATA: begin
        m_rready  = grant_q ? s1_rready : s0_rready;
        s0_rvalid = m_rvalid & ~grant_q;
        s1_rvalid = m_rvalid & grant_q;
        if (m_rvalid && m_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset leaves last_q=1 so s0 wins the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign m_araddr = addr_q;
  assign grant_id = grant_q;
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Drives two arbiters (round-robin and fixed priority) from shared stimulus and checks both against a transaction model.
module tb_mem_read_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] s0_araddr = '0, s1_araddr = '0, m_rdata = '0;
  logic        s0_arvalid = 1'b0, s0_rready = 1'b0;
  logic        s1_arvalid = 1'b0, s1_rready = 1'b0;
  logic        m_arready = 1'b0, m_rvalid = 1'b0;

  logic        a_s0_arready, a_s0_rvalid, a_s1_arready, a_s1_rvalid, a_m_arvalid, a_m_rready, a_grant_id;
  logic [31:0] a_s0_rdata, a_s1_rdata, a_m_araddr;
  logic        b_s0_arready, b_s0_rvalid, b_s1_arready, b_s1_rvalid, b_m_arvalid, b_m_rready, b_grant_id;
  logic [31:0] b_s0_rdata, b_s1_rdata, b_m_araddr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .resetn(resetn),
    .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(a_s0_arready),
    .s0_rdata(a_s0_rdata), .s0_rvalid(a_s0_rvalid), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(a_s1_arready),
    .s1_rdata(a_s1_rdata), .s1_rvalid(a_s1_rvalid), .s1_rready(s1_rready),
    .m_araddr(a_m_araddr), .m_arvalid(a_m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(a_m_rready),
    .grant_id(a_grant_id)
  );

  mem_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .resetn(resetn),
    .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(b_s0_arready),
    .s0_rdata(b_s0_rdata), .s0_rvalid(b_s0_rvalid), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(b_s1_arready),
    .s1_rdata(b_s1_rdata), .s1_rvalid(b_s1_rvalid), .s1_rready(s1_rready),
    .m_araddr(b_m_araddr), .m_arvalid(b_m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(b_m_rready),
    .grant_id(b_grant_id)
  );

  typedef struct packed {
    logic        s0_ar;
    logic        s0_rv;
    logic [31:0] s0_rd;
    logic        s1_ar;
    logic        s1_rv;
    logic [31:0] s1_rd;
    logic [31:0] m_ad;
    logic        m_av;
    logic        m_rr;
    logic        gid;
  } outs_t;

  // Transaction-level model: is a read outstanding, has memory taken its address, who owns it.
  bit          busy [2];
  bit          sent [2];
  bit          owner [2];
  bit          m_last [2];
  logic [31:0] maddr [2];
  int          waits [2];
  int          grants [2][2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      busy[k] = 0; sent[k] = 0; owner[k] = 0; m_last[k] = 1; maddr[k] = '0;
      waits[k] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic outs_t obs(input int k);
    outs_t o;
    if (k == 0) o = '{a_s0_arready, a_s0_rvalid, a_s0_rdata, a_s1_arready, a_s1_rvalid, a_s1_rdata,
                      a_m_araddr, a_m_arvalid, a_m_rready, a_grant_id};
    else        o = '{b_s0_arready, b_s0_rvalid, b_s0_rdata, b_s1_arready, b_s1_rvalid, b_s1_rdata,
                      b_m_araddr, b_m_arvalid, b_m_rready, b_grant_id};
    return o;
  endfunction

  // Who would win arbitration right now if the block is free.
  function automatic bit pick(input int k);
    if (s0_arvalid && s1_arvalid) return (k == 1) ? 1'b1 : !m_last[k];
    return s1_arvalid;
  endfunction

  function automatic outs_t predict(input int k);
    outs_t e;
    bit w;
    bit data_phase;
    e = '0;
    w = pick(k);
    data_phase = busy[k] && sent[k];
    if (!busy[k]) begin
      e.s0_ar = s0_arvalid && !w;
      e.s1_ar = s1_arvalid && w;
    end
    e.m_av  = busy[k] && !sent[k];
    e.m_ad  = maddr[k];
    e.gid   = owner[k];
    e.s0_rv = data_phase && !owner[k] && m_rvalid;
    e.s1_rv = data_phase && owner[k] && m_rvalid;
    e.m_rr  = data_phase && (owner[k] ? s1_rready : s0_rready);
    e.s0_rd = m_rdata;
    e.s1_rd = m_rdata;
    return e;
  endfunction

  // One clock: compare at negedge against the model, advance the model after the posedge.
  task automatic cycle();
    outs_t e, o;
    string p;
    bit n_busy [2];
    bit n_sent [2];
    bit n_owner [2];
    bit n_last [2];
    logic [31:0] n_addr [2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      e = predict(k);
      o = obs(k);
      p = (k == 0) ? "rr" : "fp";
      chk({p, ".s0_arready"}, o.s0_ar, e.s0_ar);
      chk({p, ".s1_arready"}, o.s1_ar, e.s1_ar);
      chk({p, ".s0_rvalid"}, o.s0_rv, e.s0_rv);
      chk({p, ".s1_rvalid"}, o.s1_rv, e.s1_rv);
      chk({p, ".s0_rdata"}, o.s0_rd, e.s0_rd);
      chk({p, ".s1_rdata"}, o.s1_rd, e.s1_rd);
      chk({p, ".m_araddr"}, o.m_ad, e.m_ad);
      chk({p, ".m_arvalid"}, o.m_av, e.m_av);
      chk({p, ".m_rready"}, o.m_rr, e.m_rr);
      chk({p, ".grant_id"}, o.gid, e.gid);
      if (o.s0_ar) grants[k][0]++;
      if (o.s1_ar) grants[k][1]++;
      if (k == 0) begin
        if (s0_arvalid && o.s1_ar) waits[0]++;
        else if (!s0_arvalid || o.s0_ar) waits[0] = 0;
        if (s1_arvalid && o.s0_ar) waits[1]++;
        else if (!s1_arvalid || o.s1_ar) waits[1] = 0;
        if (o.s0_ar || o.s1_ar) chk("rr.starvation", (waits[0] <= 1 && waits[1] <= 1), 1);
      end
      n_busy[k] = busy[k]; n_sent[k] = sent[k]; n_owner[k] = owner[k];
      n_last[k] = m_last[k]; n_addr[k] = maddr[k];
      if (!busy[k] && (s0_arvalid || s1_arvalid)) begin
        n_busy[k] = 1; n_sent[k] = 0;
        n_owner[k] = pick(k); n_last[k] = pick(k);
        n_addr[k] = pick(k) ? s1_araddr : s0_araddr;
      end else if (busy[k] && !sent[k] && m_arready) begin
        n_sent[k] = 1;
      end else if (e.m_rr && m_rvalid) begin
        n_busy[k] = 0; n_sent[k] = 0;
      end
    end
    @(posedge clk);
    #1;
    if (!resetn) model_reset();
    else begin
      for (int k = 0; k < 2; k++) begin
        busy[k] = n_busy[k]; sent[k] = n_sent[k]; owner[k] = n_owner[k];
        m_last[k] = n_last[k]; maddr[k] = n_addr[k];
      end
    end
  endtask

  task automatic quiet();
    s0_arvalid = 0; s1_arvalid = 0; s0_rready = 0; s1_rready = 0;
    m_arready = 0; m_rvalid = 0;
  endtask

  task automatic do_reset();
    quiet();
    resetn = 0;
    model_reset();
    cycle();
    cycle();
    resetn = 1;
  endtask

  initial begin
    model_reset();
    // Reset values, then a single s0 read to 0x1000.
    do_reset();
    chk("rst.m_arvalid", a_m_arvalid, 0);
    chk("rst.m_rready", a_m_rready, 0);
    chk("rst.grant_id", a_grant_id, 0);
    s0_araddr = 32'h1000; s0_arvalid = 1;
    cycle();
    s0_arvalid = 0;
    chk("t1.m_araddr", a_m_araddr, 32'h1000);
    chk("t1.m_arvalid", a_m_arvalid, 1);
    m_arready = 1;
    cycle();
    m_arready = 0; m_rvalid = 1; m_rdata = 32'h1234; s0_rready = 1;
    cycle();
    quiet();
    cycle();

    // Tie with round-robin: s0, s1, s0, s1 (fixed-priority instance: s1 every time).
    do_reset();
    grants = '{default: 0};
    s0_araddr = 32'h100; s1_araddr = 32'h200;
    s0_arvalid = 1; s1_arvalid = 1; s0_rready = 1; s1_rready = 1;
    for (int t = 0; t < 4; t++) begin
      cycle();
      m_arready = 1;
      cycle();
      m_arready = 0; m_rvalid = 1;
      m_rdata = (t % 2 == 0) ? 32'hAAAA : 32'hBBBB;
      #1;
      chk("tie.rr_s0_rvalid", a_s0_rvalid, (t % 2 == 0));
      chk("tie.rr_grant", a_grant_id, (t % 2 != 0));
      if (t == 0) chk("tie.rr_s0_rdata", a_s0_rdata, 32'hAAAA);
      chk("tie.fp_grant", b_grant_id, 1);
      cycle();
      m_rvalid = 0;
    end
    chk("tie.rr_s0_count", grants[0][0], 2);
    chk("tie.rr_s1_count", grants[0][1], 2);
    chk("tie.fp_s0_count", grants[1][0], 0);
    chk("tie.fp_s1_count", grants[1][1], 4);
    // With s1 idle, the fixed-priority instance must serve s0.
    s1_arvalid = 0;
    #1;
    chk("fp.s0_alone", b_s0_arready, 1);
    quiet();
    cycle();
    m_arready = 1; cycle(); m_arready = 0;
    m_rvalid = 1; s0_rready = 1; cycle(); quiet();

    // Address and response backpressure on an s1 transaction.
    do_reset();
    s1_araddr = 32'h200; s1_arvalid = 1;
    cycle();
    s0_arvalid = 1; s0_araddr = 32'h300;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp.m_araddr", a_m_araddr, 32'h200);
      chk("bp.no_arready", a_s0_arready | a_s1_arready, 0);
    end
    m_arready = 1;
    cycle();
    m_arready = 0; m_rvalid = 1; m_rdata = 32'h5555;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp.m_rready_low", a_m_rready, 0);
    end
    s1_rready = 1;
    #1;
    chk("bp.m_rready_high", a_m_rready, 1);
    cycle();
    quiet();

    // Stray response while idle.
    do_reset();
    m_rvalid = 1; m_rdata = 32'hDEAD; s0_rready = 1; s1_rready = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stray.m_rready", a_m_rready, 0);
      chk("stray.rvalid", a_s0_rvalid | a_s1_rvalid, 0);
    end
    quiet();

    // Asynchronous reset in the data phase.
    s0_arvalid = 1; s0_araddr = 32'h4000;
    cycle();
    s0_arvalid = 0; m_arready = 1;
    cycle();
    m_arready = 0; s0_rready = 1;
    #3;
    m_rvalid = 1;
    #1;
    chk("arst.pre_m_rready", a_m_rready, 1);
    chk("arst.pre_s0_rvalid", a_s0_rvalid, 1);
    resetn = 0;
    #1;
    chk("arst.m_rready", a_m_rready, 0);
    chk("arst.s0_rvalid", a_s0_rvalid, 0);
    chk("arst.grant_id", a_grant_id, 0);
    model_reset();
    quiet();
    cycle();
    resetn = 1;
    s0_arvalid = 1; s1_arvalid = 1;
    #1;
    chk("arst.first_tie_s0", a_s0_arready, 1);
    cycle();
    quiet();
    do_reset();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      s0_arvalid = ($urandom_range(0, 3) != 0);
      s1_arvalid = ($urandom_range(0, 3) != 0);
      s0_araddr  = $urandom;
      s1_araddr  = $urandom;
      s0_rready  = ($urandom_range(0, 2) != 0);
      s1_rready  = ($urandom_range(0, 2) != 0);
      m_arready  = ($urandom_range(0, 2) != 0);
      m_rvalid   = ($urandom_range(0, 2) != 0);
      m_rdata    = $urandom;
      cycle();
    end
    quiet();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
